// File: rtl/ysyx_22050243_mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22050243_mem_arb_pkg
// Shared types and default widths for the IFU/LSU memory arbiter.
//   state_e : arbiter sequencer states (IDLE, REQ, WAIT, DONE)
//   owner_e : which requester owns the outstanding transaction
// ----------------------------------------------------------------------------
package ysyx_22050243_mem_arb_pkg;

    localparam int ADDR_W_DEF = 64;
    localparam int DATA_W_DEF = 64;
    localparam int INST_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/ysyx_22050243_arb_pick.sv
// ----------------------------------------------------------------------------
// ysyx_22050243_arb_pick
// Combinational two-way grant. A lone valid requester always wins; on a tie
// the priority input selects the winner.
//   i_valid_i   : IFU request valid
//   i_valid_d   : LSU request valid
//   i_prio_is_d : 1 = LSU wins a tie, 0 = IFU wins a tie
//   o_grant_i   : IFU granted
//   o_grant_d   : LSU granted
// ----------------------------------------------------------------------------
module ysyx_22050243_arb_pick
    import ysyx_22050243_mem_arb_pkg::*;
(
    input  logic i_valid_i,
    input  logic i_valid_d,
    input  logic i_prio_is_d,
    output logic o_grant_i,
    output logic o_grant_d
);

    assign o_grant_d = i_valid_d && (i_prio_is_d  || !i_valid_i);
    assign o_grant_i = i_valid_i && (!i_prio_is_d || !i_valid_d);

endmodule

// File: rtl/ysyx_22050243_mem_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_22050243_mem_arbiter
// Arbitrates the IFU (instruction fetch) and LSU (load/store) onto a single
// memory port with exactly one transaction outstanding. A request is latched
// at its handshake, forwarded over the mem_req channel, and the memory
// response is held for the owning requester until it is accepted.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   ifu_req_*  / ifu_resp_*     IFU fetch request / 32-bit instruction reply
//   lsu_req_*  / lsu_resp_*     LSU load/store request / data reply (0 on store)
//   mem_req_*  / mem_resp_*     memory port request / one-cycle response pulse
//
// Build option:
//   MEM_ARB_RR_EN  defined   -> round-robin tie break (IFU wins the first tie)
//                  undefined -> fixed LSU-over-IFU priority
// ----------------------------------------------------------------------------
module ysyx_22050243_mem_arbiter
    import ysyx_22050243_mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int INST_W = INST_W_DEF,
    parameter int MASK_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_req_addr,
    output logic              ifu_resp_valid,
    input  logic              ifu_resp_ready,
    output logic [INST_W-1:0] ifu_resp_inst,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_req_wen,
    input  logic [ADDR_W-1:0] lsu_req_addr,
    input  logic [DATA_W-1:0] lsu_req_wdata,
    input  logic [MASK_W-1:0] lsu_req_wmask,
    output logic              lsu_resp_valid,
    input  logic              lsu_resp_ready,
    output logic [DATA_W-1:0] lsu_resp_rdata,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wen,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [MASK_W-1:0] mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata
);

    state_e            r_state;
    state_e            w_state_nxt;
    owner_e            r_owner;
    logic              r_wen;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [MASK_W-1:0] r_wmask;
    logic [DATA_W-1:0] r_rdata;

    logic              w_prio_is_d;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_accept;
    logic              w_capture;

    ysyx_22050243_arb_pick u_pick (
        .i_valid_i   (ifu_req_valid),
        .i_valid_d   (lsu_req_valid),
        .i_prio_is_d (w_prio_is_d),
        .o_grant_i   (w_grant_i),
        .o_grant_d   (w_grant_d)
    );

`ifdef MEM_ARB_RR_EN
    // Remembers the last granted owner; the other requester wins the next tie.
    owner_e r_last_owner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_owner <= OWN_D;
        end else if (w_accept) begin
            r_last_owner <= w_grant_d ? OWN_D : OWN_I;
        end
    end

    assign w_prio_is_d = (r_last_owner == OWN_I);
`else
    assign w_prio_is_d = 1'b1;
`endif

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_accept       = 1'b0;
        w_capture      = 1'b0;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        mem_req_valid  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;

        case (r_state)
            IDLE: begin
                // Readies are qualified by rst_n so nothing is offered while
                // reset is held, even if a requester already drives valid.
                ifu_req_ready = w_grant_i && rst_n;
                lsu_req_ready = w_grant_d && rst_n;
                if (w_grant_i || w_grant_d) begin
                    w_accept    = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    // A response in the handshake cycle skips WAIT entirely.
                    if (mem_resp_valid) begin
                        w_capture   = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                ifu_resp_valid = (r_owner == OWN_I);
                lsu_resp_valid = (r_owner == OWN_D);
                if ((r_owner == OWN_I) ? ifu_resp_ready : lsu_resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_owner <= OWN_I;
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wmask <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                if (w_grant_d) begin
                    r_owner <= OWN_D;
                    r_wen   <= lsu_req_wen;
                    r_addr  <= lsu_req_addr;
                    // Write payload is zeroed for loads so reads carry no mask.
                    r_wdata <= lsu_req_wen ? lsu_req_wdata : '0;
                    r_wmask <= lsu_req_wen ? lsu_req_wmask : '0;
                end else begin
                    r_owner <= OWN_I;
                    r_wen   <= 1'b0;
                    r_addr  <= ifu_req_addr;
                    r_wdata <= '0;
                    r_wmask <= '0;
                end
            end
            if (w_capture) begin
                r_rdata <= r_wen ? '0 : mem_resp_rdata;
            end
        end
    end

    assign mem_req_wen    = r_wen;
    assign mem_req_addr   = r_addr;
    assign mem_req_wdata  = r_wdata;
    assign mem_req_wmask  = r_wmask;
    assign lsu_resp_rdata = r_rdata;
    // Address bit 2 picks the upper or lower instruction of the 64-bit word.
    assign ifu_resp_inst  = r_addr[2] ? r_rdata[2*INST_W-1:INST_W]
                                      : r_rdata[INST_W-1:0];

endmodule

// File: tb/tb_ysyx_22050243_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22050243_mem_arbiter
// Directed scenarios followed by randomized IFU/LSU/memory traffic checked
// against a transaction-level model of the arbiter and a bench-side memory.
// Honours MEM_ARB_RR_EN for the expected tie-break order.
// ----------------------------------------------------------------------------
module tb_ysyx_22050243_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [63:0] ifu_req_addr;
    logic [31:0] ifu_resp_inst;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid, lsu_resp_ready;
    logic [63:0] lsu_req_addr, lsu_req_wdata, lsu_resp_rdata;
    logic [7:0]  lsu_req_wmask;
    logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid;
    logic [63:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
    logic [7:0]  mem_req_wmask;

    ysyx_22050243_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_req_addr(ifu_req_addr), .ifu_resp_valid(ifu_resp_valid),
        .ifu_resp_ready(ifu_resp_ready), .ifu_resp_inst(ifu_resp_inst),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_req_wen(lsu_req_wen), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
        .lsu_resp_rdata(lsu_resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Tie-break model: 1 when the LSU should win a simultaneous request.
    bit rr_last_d = 1'b1;

    function automatic bit d_wins_tie();
`ifdef MEM_ARB_RR_EN
        return !rr_last_d;
`else
        return 1'b1;
`endif
    endfunction

    task automatic note_grant(input bit to_d);
        rr_last_d = to_d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pick the instruction half selected by address bit 2.
    function automatic logic [31:0] inst_of(input logic [63:0] addr, input logic [63:0] word);
        return addr[2] ? word[63:32] : word[31:0];
    endfunction

    // Bench memory: 64-bit words keyed by address/8, with a deterministic
    // fill pattern for words never written.
    logic [63:0] mem [logic [63:0]];

    function automatic logic [63:0] rd_word(input logic [63:0] addr);
        logic [63:0] key;
        key = addr >> 3;
        if (mem.exists(key)) return mem[key];
        return {key[31:0] ^ 32'h5a5a_1234, ~key[31:0]};
    endfunction

    task automatic wr_word(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] mask);
        logic [63:0] w;
        w = rd_word(addr);
        for (int j = 0; j < 8; j++) if (mask[j]) w[j*8 +: 8] = data[j*8 +: 8];
        mem[addr >> 3] = w;
    endtask

    task automatic check_all_quiet(input string tag);
        check({tag, "_ifu_req_ready"},  ifu_req_ready,  1'b0);
        check({tag, "_lsu_req_ready"},  lsu_req_ready,  1'b0);
        check({tag, "_mem_req_valid"},  mem_req_valid,  1'b0);
        check({tag, "_ifu_resp_valid"}, ifu_resp_valid, 1'b0);
        check({tag, "_lsu_resp_valid"}, lsu_resp_valid, 1'b0);
        check({tag, "_mem_req_addr"},   mem_req_addr,   64'h0);
        check({tag, "_mem_req_wmask"},  mem_req_wmask,  8'h0);
        check({tag, "_lsu_resp_rdata"}, lsu_resp_rdata, 64'h0);
    endtask

    // Serves the transaction just granted (IDLE cycle already sampled) with a
    // memory that accepts and answers in the same cycle; the owner's response
    // must appear two cycles after the grant and is accepted at once.
    task automatic serve_immediate(input bit own_d, input logic [63:0] data);
        logic [63:0] exp_addr;
        bit          wen;
        exp_addr = own_d ? lsu_req_addr : ifu_req_addr;
        wen      = own_d && lsu_req_wen;
        step();
        if (own_d) lsu_req_valid = 1'b0; else ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = data;
        @(negedge clk);
        check("imm_mem_req_valid", mem_req_valid, 1'b1);
        check("imm_mem_req_addr", mem_req_addr, exp_addr);
        step();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 64'hbad0_bad0_bad0_bad0;
        if (own_d) lsu_resp_ready = 1'b1; else ifu_resp_ready = 1'b1;
        @(negedge clk);
        check("lat2_ifu_resp_valid", ifu_resp_valid, !own_d);
        check("lat2_lsu_resp_valid", lsu_resp_valid, own_d);
        if (own_d) check("lat2_lsu_rdata", lsu_resp_rdata, wen ? 64'h0 : data);
        else       check("lat2_ifu_inst", ifu_resp_inst, inst_of(exp_addr, data));
        step();
        ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
    endtask

    // Transaction-level model state for the random phase.
    typedef struct {
        bit          active;
        bit          d;
        bit          wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        bit          taken;
        bit          have;
        logic [63:0] rdata;
        int          delay;
        int          waited;
    } txn_t;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        bit   i_acc, d_acc, first_d, exp_ri, exp_rd;

        rst_n = 1'b0;
        ifu_req_valid = 1'b1; ifu_req_addr = 64'h8000_0000; ifu_resp_ready = 1'b0;
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b0; lsu_req_addr = 64'h0;
        lsu_req_wdata = 64'h0; lsu_req_wmask = 8'h0; lsu_resp_ready = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 64'h0;

        // ---- reset state, with requesters already asserting valid ----
        #12;
        @(negedge clk);
        check_all_quiet("rst");
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        step();
        rst_n = 1'b1;

        // ---- IFU fetch alone, response one cycle after the request ----
        ifu_req_valid = 1'b1; ifu_req_addr = 64'h8000_0004;
        @(negedge clk);
        check("fetch_ifu_req_ready", ifu_req_ready, 1'b1);
        check("fetch_lsu_req_ready", lsu_req_ready, 1'b0);
        note_grant(1'b0);
        step();
        ifu_req_valid = 1'b0; ifu_req_addr = 64'h0; mem_req_ready = 1'b1;
        @(negedge clk);
        check("fetch_mem_req_valid", mem_req_valid, 1'b1);
        check("fetch_mem_req_addr", mem_req_addr, 64'h8000_0004);
        check("fetch_mem_req_wen", mem_req_wen, 1'b0);
        check("fetch_mem_req_wmask", mem_req_wmask, 8'h0);
        step();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 64'h1111_2222_3333_4444;
        @(negedge clk);
        check("fetch_wait_ifu_resp_valid", ifu_resp_valid, 1'b0);
        step();
        mem_resp_valid = 1'b0; mem_resp_rdata = 64'hffff_ffff_ffff_ffff;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("fetch_hold_ifu_resp_valid", ifu_resp_valid, 1'b1);
            check("fetch_hold_ifu_inst", ifu_resp_inst, 32'h1111_2222);
            check("fetch_hold_lsu_resp_valid", lsu_resp_valid, 1'b0);
            step();
        end
        ifu_resp_ready = 1'b1;
        @(negedge clk);
        check("fetch_hs_ifu_resp_valid", ifu_resp_valid, 1'b1);
        step();
        ifu_resp_ready = 1'b0;
        @(negedge clk);
        check("fetch_after_ifu_resp_valid", ifu_resp_valid, 1'b0);
        step();

        // ---- LSU store with memory backpressure and response stall ----
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b1; lsu_req_addr = 64'h8000_1000;
        lsu_req_wdata = 64'hDEAD_BEEF; lsu_req_wmask = 8'h0F;
        ifu_req_valid = 1'b1; ifu_req_addr = 64'h8000_0010;
        @(negedge clk);
        check("store_lsu_req_ready", lsu_req_ready, 1'b1);
        check("store_ifu_req_ready", ifu_req_ready, 1'b0);
        note_grant(1'b1);
        step();
        lsu_req_valid = 1'b0; lsu_req_wdata = 64'h0123_4567_89ab_cdef;
        lsu_req_wmask = 8'hF0; lsu_req_addr = 64'h0; mem_req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_mem_req_valid", mem_req_valid, 1'b1);
            check("bp_mem_req_wen", mem_req_wen, 1'b1);
            check("bp_mem_req_addr", mem_req_addr, 64'h8000_1000);
            check("bp_mem_req_wdata", mem_req_wdata, 64'hDEAD_BEEF);
            check("bp_mem_req_wmask", mem_req_wmask, 8'h0F);
            check("bp_ifu_req_ready", ifu_req_ready, 1'b0);
            check("bp_lsu_req_ready", lsu_req_ready, 1'b0);
            step();
        end
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = 64'hffff_ffff_ffff_ffff;
        @(negedge clk);
        check("store_mem_req_valid", mem_req_valid, 1'b1);
        step();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; lsu_resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_lsu_resp_valid", lsu_resp_valid, 1'b1);
            check("stall_lsu_rdata", lsu_resp_rdata, 64'h0);
            check("stall_ifu_resp_valid", ifu_resp_valid, 1'b0);
            check("stall_ifu_req_ready", ifu_req_ready, 1'b0);
            step();
        end
        lsu_resp_ready = 1'b1;
        @(negedge clk);
        check("stall_hs_lsu_resp_valid", lsu_resp_valid, 1'b1);
        check("stall_hs_ifu_req_ready", ifu_req_ready, 1'b0);
        step();

        // ---- simultaneous valids: tie break, then the other requester ----
        lsu_resp_ready = 1'b0;
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b0; lsu_req_addr = 64'h8000_2008;
        @(negedge clk);
        first_d = d_wins_tie();
        check("tie1_ifu_req_ready", ifu_req_ready, !first_d);
        check("tie1_lsu_req_ready", lsu_req_ready, first_d);
        note_grant(first_d);
        serve_immediate(first_d, 64'h0a0b_0c0d_1a1b_1c1d);
        @(negedge clk);
        check("tie2_ifu_req_ready", ifu_req_ready, first_d);
        check("tie2_lsu_req_ready", lsu_req_ready, !first_d);
        note_grant(!first_d);
        serve_immediate(!first_d, 64'h5566_7788_99aa_bbcc);
        @(negedge clk);
        check("tie_done_ifu_req_ready", ifu_req_ready, 1'b0);
        check("tie_done_lsu_req_ready", lsu_req_ready, 1'b0);
        step();

        // ---- reset while waiting for memory, then a stray response ----
        ifu_req_valid = 1'b1; ifu_req_addr = 64'h8000_0008;
        @(negedge clk);
        check("wrst_ifu_req_ready", ifu_req_ready, 1'b1);
        step();
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        check("wrst_mem_req_valid", mem_req_valid, 1'b1);
        step();
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_quiet("wrst");
        rr_last_d = 1'b1;
        step();
        rst_n = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = 64'h7777_7777_7777_7777;
        @(negedge clk);
        check("stray_mem_req_valid", mem_req_valid, 1'b0);
        check("stray_ifu_resp_valid", ifu_resp_valid, 1'b0);
        step();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        check("stray_after_ifu_resp_valid", ifu_resp_valid, 1'b0);
        check("stray_after_lsu_resp_valid", lsu_resp_valid, 1'b0);
        step();

        // ---- randomized traffic against the transaction model ----
        t = '{default: 0};
        i_acc = 1'b0; d_acc = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            // Requesters: hold a pending request, otherwise maybe issue one.
            if (!ifu_req_valid || i_acc) begin
                ifu_req_valid = $urandom_range(0, 1);
                ifu_req_addr  = 64'h8000_0000 + 64'($urandom_range(0, 31)) * 4;
            end
            if (!lsu_req_valid || d_acc) begin
                lsu_req_valid = $urandom_range(0, 1);
                lsu_req_wen   = $urandom_range(0, 1);
                lsu_req_addr  = 64'h8000_0000 + 64'($urandom_range(0, 15)) * 8;
                lsu_req_wdata = {$urandom, $urandom};
                lsu_req_wmask = 8'($urandom);
            end
            ifu_resp_ready = ($urandom_range(0, 4) < 3);
            lsu_resp_ready = ($urandom_range(0, 4) < 3);

            // Memory: random acceptance and 0..2 cycle response delay.
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            mem_resp_rdata = {$urandom, $urandom};
            if (t.active && !t.taken) begin
                mem_req_ready  = ($urandom_range(0, 2) != 0);
                mem_resp_valid = mem_req_ready && (t.delay == 0);
            end else if (t.active && !t.have && t.waited >= t.delay) begin
                mem_resp_valid = 1'b1;
            end
            if (mem_resp_valid && !t.wen) mem_resp_rdata = rd_word(t.addr);

            @(negedge clk);
            exp_ri = !t.active && ifu_req_valid && (!lsu_req_valid || !d_wins_tie());
            exp_rd = !t.active && lsu_req_valid && (!ifu_req_valid ||  d_wins_tie());
            check("rnd_ifu_req_ready", ifu_req_ready, exp_ri);
            check("rnd_lsu_req_ready", lsu_req_ready, exp_rd);
            check("rnd_mem_req_valid", mem_req_valid, t.active && !t.taken);
            if (t.active && !t.taken) begin
                check("rnd_mem_req_addr", mem_req_addr, t.addr);
                check("rnd_mem_req_wen", mem_req_wen, t.wen);
                check("rnd_mem_req_wmask", mem_req_wmask, t.wen ? t.wmask : 8'h0);
                if (t.wen) check("rnd_mem_req_wdata", mem_req_wdata, t.wdata);
            end
            check("rnd_ifu_resp_valid", ifu_resp_valid, t.active && t.have && !t.d);
            check("rnd_lsu_resp_valid", lsu_resp_valid, t.active && t.have && t.d);
            if (t.active && t.have) begin
                if (t.d) check("rnd_lsu_rdata", lsu_resp_rdata, t.rdata);
                else     check("rnd_ifu_inst", ifu_resp_inst, inst_of(t.addr, t.rdata));
            end

            // Advance the model with this cycle's expected handshakes.
            i_acc = 1'b0; d_acc = 1'b0;
            if (!t.active) begin
                if (exp_ri || exp_rd) begin
                    t.active = 1'b1; t.d = exp_rd; t.taken = 1'b0; t.have = 1'b0;
                    t.wen    = exp_rd && lsu_req_wen;
                    t.addr   = exp_rd ? lsu_req_addr : ifu_req_addr;
                    t.wdata  = lsu_req_wdata; t.wmask = lsu_req_wmask;
                    t.delay  = $urandom_range(0, 2); t.waited = 0;
                    note_grant(exp_rd);
                    i_acc = exp_ri; d_acc = exp_rd;
                end
            end else if (!t.taken) begin
                if (mem_req_ready) begin
                    t.taken  = 1'b1;
                    t.waited = 1;
                    t.rdata  = t.wen ? 64'h0 : rd_word(t.addr);
                    if (t.wen) wr_word(t.addr, t.wdata, t.wmask);
                    if (mem_resp_valid) t.have = 1'b1;
                end
            end else if (!t.have) begin
                if (mem_resp_valid) t.have = 1'b1;
                else t.waited++;
            end else if (t.d ? lsu_resp_ready : ifu_resp_ready) begin
                t.active = 1'b0;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
